// File: rtl/tone_freq_meter_if.sv
// rtl/tone_freq_meter_if.sv - sample bus and measurement results of the tone frequency meter
interface tone_freq_meter_if #(
    parameter int FREQ_BITS   = 16,
    parameter int PERIOD_BITS = 24
);
    logic [7:0]             sample;
    logic [FREQ_BITS-1:0]   freq;
    logic                   freq_valid;
    logic                   tone_present;
    logic [PERIOD_BITS-1:0] period_cycles;
    logic                   period_valid;

    // Tone source side: drives samples, observes measurements
    modport master (
        output sample,
        input  freq,
        input  freq_valid,
        input  tone_present,
        input  period_cycles,
        input  period_valid
    );

    // Meter side: consumes samples, produces measurements
    modport slave (
        input  sample,
        output freq,
        output freq_valid,
        output tone_present,
        output period_cycles,
        output period_valid
    );
endinterface

// File: rtl/tone_freq_meter.sv
// rtl/tone_freq_meter.sv - rising midscale crossing counter giving tone frequency and period
module tone_freq_meter #(
    parameter int GATE_CYCLES = 12000000,
    parameter int GATE_BITS   = 24,
    parameter int MID         = 128,
    parameter int HYST        = 16,
    parameter int FREQ_BITS   = 16,
    parameter int PERIOD_BITS = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    tone_freq_meter_if.slave bus
);
    // Thresholds kept one bit wider than the sample so MID+HYST above 255 never wraps
    localparam logic [8:0]             HI        = 9'(MID + HYST);
    localparam logic [8:0]             LO        = 9'(MID - HYST);
    localparam logic [GATE_BITS-1:0]   GATE_LAST = GATE_BITS'(GATE_CYCLES - 1);
    localparam logic [FREQ_BITS-1:0]   FREQ_MAX  = '1;
    localparam logic [PERIOD_BITS-1:0] PER_MAX   = '1;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } cmp_state_t;

    cmp_state_t             state;
    cmp_state_t             state_next;
    logic [7:0]             sample_q;
    logic                   above_hi;
    logic                   below_lo;
    logic                   rise;
    logic                   gate_end;
    logic [GATE_BITS-1:0]   gate_cnt;
    logic [FREQ_BITS-1:0]   edge_cnt;
    logic [FREQ_BITS-1:0]   edge_sum;
    logic [PERIOD_BITS-1:0] per_cnt;
    logic                   armed;
    logic [FREQ_BITS-1:0]   freq_r;
    logic                   freq_valid_r;
    logic                   tone_present_r;
    logic [PERIOD_BITS-1:0] period_r;
    logic                   period_valid_r;

    assign above_hi = {1'b0, sample_q} >= HI;
    assign below_lo = {1'b0, sample_q} < LO;
    assign gate_end = (gate_cnt == GATE_LAST);

    // Register the incoming sample once; everything downstream works on sample_q
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_q <= '0;
        end else begin
            sample_q <= bus.sample;
        end
    end

    // Comparator state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_LOW;
        end else begin
            state <= state_next;
        end
    end

    // Hysteresis transitions: only leave a state once the opposite threshold is crossed
    always_comb begin
        state_next = state;
        case (state)
            ST_LOW:  if (above_hi) state_next = ST_HIGH;
            ST_HIGH: if (below_lo) state_next = ST_LOW;
            default: state_next = ST_LOW;
        endcase
    end

    // Rising crossing is the LOW->HIGH transition itself, visible in the same cycle
    always_comb begin
        rise = 1'b0;
        if (state == ST_LOW && above_hi) begin
            rise = 1'b1;
        end
    end

    // Gate window counter, free running 0..GATE_CYCLES-1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gate_cnt <= '0;
        end else if (gate_end) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + 1'b1;
        end
    end

    // Edge count including this cycle's rise, saturating so a runaway tone pins at all-ones
    always_comb begin
        edge_sum = edge_cnt;
        if (rise && edge_cnt != FREQ_MAX) begin
            edge_sum = edge_cnt + 1'b1;
        end
    end

    // Close the window at gate end; a coincident rise belongs to the window being closed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_cnt       <= '0;
            freq_r         <= '0;
            freq_valid_r   <= 1'b0;
            tone_present_r <= 1'b0;
        end else begin
            freq_valid_r <= gate_end;
            if (gate_end) begin
                edge_cnt       <= '0;
                freq_r         <= edge_sum;
                tone_present_r <= (edge_sum != '0);
            end else begin
                edge_cnt <= edge_sum;
            end
        end
    end

    // Period counter: restarts at 1 on each rise so it holds the exact crossing spacing at the next rise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_cnt        <= '0;
            armed          <= 1'b0;
            period_r       <= '0;
            period_valid_r <= 1'b0;
        end else begin
            period_valid_r <= rise && armed;
            if (rise) begin
                per_cnt <= PERIOD_BITS'(1);
                armed   <= 1'b1;
                if (armed) begin
                    period_r <= per_cnt;
                end
            end else if (per_cnt != PER_MAX) begin
                per_cnt <= per_cnt + 1'b1;
            end
        end
    end

    assign bus.freq          = freq_r;
    assign bus.freq_valid    = freq_valid_r;
    assign bus.tone_present  = tone_present_r;
    assign bus.period_cycles = period_r;
    assign bus.period_valid  = period_valid_r;
endmodule

// File: tb/tb_tone_freq_meter.sv
// tb/tb_tone_freq_meter.sv - directed self-checking bench for tone_freq_meter
module tb_tone_freq_meter;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    tone_freq_meter_if #(.FREQ_BITS(16), .PERIOD_BITS(24)) bus_a ();
    tone_freq_meter_if #(.FREQ_BITS(4),  .PERIOD_BITS(8))  bus_b ();

    tone_freq_meter #(
        .GATE_CYCLES(5120), .GATE_BITS(13), .MID(128), .HYST(16),
        .FREQ_BITS(16), .PERIOD_BITS(24)
    ) dut_a (
        .clk(clk), .rst_n(rst_a), .bus(bus_a)
    );

    tone_freq_meter #(
        .GATE_CYCLES(1000), .GATE_BITS(10), .MID(128), .HYST(16),
        .FREQ_BITS(4), .PERIOD_BITS(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_b), .bus(bus_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
    endtask

    task automatic reset_b();
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
    endtask

    task automatic test_reset();
        int pv;
        bus_a.sample = 8'd255;
        bus_b.sample = 8'd255;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) tick();
        n_cmp++; if (bus_a.freq !== 16'd0) begin n_bad++; $display("FAIL rst_freq: got %0d expected 0", bus_a.freq); end
        n_cmp++; if (bus_a.freq_valid !== 1'b0) begin n_bad++; $display("FAIL rst_freq_valid: got %0b expected 0", bus_a.freq_valid); end
        n_cmp++; if (bus_a.tone_present !== 1'b0) begin n_bad++; $display("FAIL rst_tone_present: got %0b expected 0", bus_a.tone_present); end
        n_cmp++; if (bus_a.period_cycles !== 24'd0) begin n_bad++; $display("FAIL rst_period: got %0d expected 0", bus_a.period_cycles); end
        n_cmp++; if (bus_a.period_valid !== 1'b0) begin n_bad++; $display("FAIL rst_period_valid: got %0b expected 0", bus_a.period_valid); end
        n_cmp++; if (bus_b.freq !== 4'd0 || bus_b.period_cycles !== 8'd0) begin n_bad++; $display("FAIL rst_b_outputs: got freq %0d period %0d expected 0/0", bus_b.freq, bus_b.period_cycles); end
        rst_a = 1'b1;
        rst_b = 1'b1;
        // First rise only arms; a second rise 11 cycles later is the only period report
        pv = 0;
        for (int k = 0; k < 20; k++) begin
            bus_a.sample = (k >= 6 && k < 11) ? 8'd0 : 8'd255;
            tick();
            if (bus_a.period_valid) begin
                pv++;
                n_cmp++; if (bus_a.period_cycles !== 24'd11) begin n_bad++; $display("FAIL first_period: got %0d expected 11", bus_a.period_cycles); end
                n_cmp++; if (k != 12) begin n_bad++; $display("FAIL first_period_time: got k=%0d expected k=12", k); end
            end
        end
        n_cmp++; if (pv != 1) begin n_bad++; $display("FAIL arm_only_first_rise: got %0d period_valid expected 1", pv); end
    endtask

    task automatic test_sawtooth();
        int fv;
        int pv;
        bus_a.sample = 8'd0;
        reset_a();
        fv = 0;
        pv = 0;
        for (int k = 0; k < 15360; k++) begin
            bus_a.sample = 8'((k >> 1) & 255);
            tick();
            if (bus_a.freq_valid) begin
                fv++;
                n_cmp++; if (bus_a.freq !== 16'd10) begin n_bad++; $display("FAIL saw_freq: got %0d expected 10", bus_a.freq); end
                n_cmp++; if (bus_a.tone_present !== 1'b1) begin n_bad++; $display("FAIL saw_tone_present: got %0b expected 1", bus_a.tone_present); end
                n_cmp++; if ((k + 1) % 5120 != 0) begin n_bad++; $display("FAIL saw_gate_time: got k=%0d expected multiple of 5120 minus 1", k); end
            end
            if (bus_a.period_valid) begin
                pv++;
                n_cmp++; if (bus_a.period_cycles !== 24'd512) begin n_bad++; $display("FAIL saw_period: got %0d expected 512", bus_a.period_cycles); end
            end
        end
        n_cmp++; if (fv != 3) begin n_bad++; $display("FAIL saw_freq_valid_count: got %0d expected 3", fv); end
        n_cmp++; if (pv != 29) begin n_bad++; $display("FAIL saw_period_valid_count: got %0d expected 29", pv); end
    endtask

    task automatic test_in_band();
        int fv;
        int pv;
        fv = 0;
        pv = 0;
        for (int k = 0; k < 5120; k++) begin
            if (k < 20) bus_a.sample = 8'd0;
            else bus_a.sample = (((k - 20) / 100) % 2 == 0) ? 8'd140 : 8'd120;
            tick();
            if (k == 0) begin
                n_cmp++; if (bus_a.freq !== 16'd10 || bus_a.tone_present !== 1'b1) begin n_bad++; $display("FAIL band_hold: got freq %0d tone %0b expected 10/1", bus_a.freq, bus_a.tone_present); end
            end
            if (bus_a.freq_valid) begin
                fv++;
                n_cmp++; if (bus_a.freq !== 16'd0) begin n_bad++; $display("FAIL band_freq: got %0d expected 0", bus_a.freq); end
                n_cmp++; if (bus_a.tone_present !== 1'b0) begin n_bad++; $display("FAIL band_tone_present: got %0b expected 0", bus_a.tone_present); end
                n_cmp++; if (k != 5119) begin n_bad++; $display("FAIL band_gate_time: got k=%0d expected 5119", k); end
            end
            if (bus_a.period_valid) pv++;
        end
        n_cmp++; if (fv != 1) begin n_bad++; $display("FAIL band_freq_valid_count: got %0d expected 1", fv); end
        n_cmp++; if (pv != 0) begin n_bad++; $display("FAIL band_no_rise: got %0d period_valid expected 0", pv); end
    endtask

    task automatic test_gate_edge();
        int fv;
        int pv;
        int exp_per [3] = '{200, 200, 255};
        bus_b.sample = 8'd0;
        reset_b();
        fv = 0;
        pv = 0;
        for (int k = 0; k < 2000; k++) begin
            bus_b.sample = ((k >= 100 && k < 110) || (k >= 300 && k < 310) ||
                            (k >= 500 && k < 510) || (k >= 998 && k < 1100)) ? 8'd255 : 8'd0;
            tick();
            if (bus_b.freq_valid) begin
                fv++;
                if (fv == 1) begin
                    n_cmp++; if (bus_b.freq !== 4'd4 || bus_b.tone_present !== 1'b1) begin n_bad++; $display("FAIL edge_close_freq: got %0d tone %0b expected 4/1", bus_b.freq, bus_b.tone_present); end
                    n_cmp++; if (k != 999) begin n_bad++; $display("FAIL edge_close_time: got k=%0d expected 999", k); end
                end else begin
                    n_cmp++; if (bus_b.freq !== 4'd0 || bus_b.tone_present !== 1'b0) begin n_bad++; $display("FAIL edge_next_freq: got %0d tone %0b expected 0/0", bus_b.freq, bus_b.tone_present); end
                end
            end
            if (bus_b.period_valid) begin
                if (pv < 3) begin
                    n_cmp++; if (bus_b.period_cycles !== 8'(exp_per[pv])) begin n_bad++; $display("FAIL edge_period%0d: got %0d expected %0d", pv, bus_b.period_cycles, exp_per[pv]); end
                end
                pv++;
            end
        end
        n_cmp++; if (fv != 2) begin n_bad++; $display("FAIL edge_freq_valid_count: got %0d expected 2", fv); end
        n_cmp++; if (pv != 3) begin n_bad++; $display("FAIL edge_period_valid_count: got %0d expected 3", pv); end
    endtask

    task automatic test_saturation();
        int fv;
        int pv;
        int exp_p;
        bus_b.sample = 8'd0;
        reset_b();
        fv = 0;
        pv = 0;
        for (int k = 0; k < 2000; k++) begin
            if (k < 400) bus_b.sample = (k % 20 < 5) ? 8'd255 : 8'd0;
            else if ((k >= 1100 && k < 1500) || k >= 1510) bus_b.sample = 8'd255;
            else bus_b.sample = 8'd0;
            tick();
            if (bus_b.freq_valid) begin
                fv++;
                if (fv == 1) begin
                    n_cmp++; if (bus_b.freq !== 4'd15 || bus_b.tone_present !== 1'b1) begin n_bad++; $display("FAIL sat_freq: got %0d tone %0b expected 15/1", bus_b.freq, bus_b.tone_present); end
                end else begin
                    n_cmp++; if (bus_b.freq !== 4'd2 || bus_b.tone_present !== 1'b1) begin n_bad++; $display("FAIL sat_second_freq: got %0d tone %0b expected 2/1", bus_b.freq, bus_b.tone_present); end
                end
            end
            if (bus_b.period_valid) begin
                exp_p = (pv < 19) ? 20 : 255;
                n_cmp++; if (bus_b.period_cycles !== 8'(exp_p)) begin n_bad++; $display("FAIL sat_period%0d: got %0d expected %0d", pv, bus_b.period_cycles, exp_p); end
                pv++;
            end
        end
        n_cmp++; if (fv != 2) begin n_bad++; $display("FAIL sat_freq_valid_count: got %0d expected 2", fv); end
        n_cmp++; if (pv != 21) begin n_bad++; $display("FAIL sat_period_valid_count: got %0d expected 21", pv); end
    endtask

    task automatic test_reset_abort();
        int fv;
        int first_j;
        bus_a.sample = 8'd0;
        reset_a();
        fv = 0;
        for (int k = 0; k < 5000; k++) begin
            bus_a.sample = (k < 4000 && k % 200 < 10) ? 8'd255 : 8'd0;
            tick();
            if (bus_a.freq_valid) fv++;
        end
        n_cmp++; if (fv != 0) begin n_bad++; $display("FAIL abort_pre_window: got %0d freq_valid expected 0", fv); end
        bus_a.sample = 8'd0;
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        fv = 0;
        first_j = 0;
        for (int j = 1; j <= 5120; j++) begin
            tick();
            if (bus_a.freq_valid) begin
                fv++;
                if (first_j == 0) first_j = j;
                n_cmp++; if (bus_a.freq !== 16'd0 || bus_a.tone_present !== 1'b0) begin n_bad++; $display("FAIL abort_freq: got %0d tone %0b expected 0/0", bus_a.freq, bus_a.tone_present); end
            end
        end
        n_cmp++; if (first_j != 5120) begin n_bad++; $display("FAIL abort_first_gate: got cycle %0d expected 5120", first_j); end
        n_cmp++; if (fv != 1) begin n_bad++; $display("FAIL abort_freq_valid_count: got %0d expected 1", fv); end
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.sample = 8'd0;
        bus_b.sample = 8'd0;
        test_reset();
        test_sawtooth();
        test_in_band();
        test_gate_edge();
        test_saturation();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
